// File: rtl/mby_msh_pkg.sv
// ============================================================================
// Module   : mby_msh_pkg
// Brief    : Shared widths, bus types and defaults for the mesh row read path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mby_msh_pkg;

   localparam int MSH_ADDR_W           = 16;
   localparam int MSH_ID_W             = 8;
   localparam int MSH_DBUS_W           = 64;
   localparam int MSH_CRDT_W           = 2;
   localparam int MSH_ROW_RD_REQ_DEPTH = 8;
   localparam int MSH_ROW_RD_RSP_CRDTS = 4;

   typedef logic [MSH_DBUS_W-1:0] msh_dbus_t;
   typedef logic [MSH_CRDT_W-1:0] msh_row_crdts_t;

   typedef struct packed {
      logic                  vld;
      logic [MSH_ADDR_W-1:0] addr;
      logic [MSH_ID_W-1:0]   id;
   } msh_row_rd_req_t;

   typedef struct packed {
      logic                vld;
      logic [MSH_ID_W-1:0] id;
   } msh_row_rd_rsp_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } msh_row_rd_rsp_fsm_t;

endpackage

`default_nettype wire

// File: rtl/mby_msh_row_rd_req_fifo.sv
// ============================================================================
// Module   : mby_msh_row_rd_req_fifo
// Brief    : Flop-based synchronous FIFO with full/empty flags; the caller
//            guarantees no write when full unless a read happens the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mby_msh_row_rd_req_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic             cclk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int              c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);

   logic [c_AW:0]     r_wr_ptr;
   logic [c_AW:0]     r_rd_ptr;
   logic [WIDTH-1:0]  r_mem [DEPTH];

   // Index wraps at DEPTH (not a power of two in general); MSB toggles per lap.
   function automatic logic [c_AW:0] f_ptr_inc(input logic [c_AW:0] ptr);
      if (ptr[c_AW-1:0] == c_LAST) begin
         return {~ptr[c_AW], {c_AW{1'b0}}};
      end
      return ptr + {{c_AW{1'b0}}, 1'b1};
   endfunction

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (i_rd_en) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
   end

   always_ff @(posedge cclk) begin
      if (i_wr_en) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
   end

endmodule

`default_nettype wire

// File: rtl/mby_msh_row_rd_rsp_ctrl.sv
// ============================================================================
// Module   : mby_msh_row_rd_rsp_ctrl
// Brief    : Responder for one mesh row read plane: credited request FIFO,
//            fixed-latency storage issue, credited response return.
//            Optional MBY_MSH_ROW_RD_RSP_ERR_CHK_EN builds sticky o_err and SVA.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mby_msh_row_rd_rsp_ctrl
   import mby_msh_pkg::*;
#(
   parameter int REQ_DEPTH = MSH_ROW_RD_REQ_DEPTH,
   parameter int RSP_CRDTS = MSH_ROW_RD_RSP_CRDTS,
   parameter int MEM_LAT   = 3
) (
   input  logic                  cclk,
   input  logic                  rst_n,
   input  msh_row_rd_req_t       i_rd_req,
   output msh_row_crdts_t        o_crdt_rtns_for_rd_reqs,
   output msh_row_rd_rsp_t       o_rd_rsp,
   output msh_dbus_t             o_rd_dbus,
   input  logic                  i_crdt_rtn_for_rd_rsp,
   output logic                  o_mem_rd_en,
   output logic [MSH_ADDR_W-1:0] o_mem_rd_addr,
   input  msh_dbus_t             i_mem_rd_data,
   output logic [1:0]            o_err
);

   localparam int                   c_PEND_W    = $clog2(REQ_DEPTH + 1);
   localparam int                   c_RSP_W     = $clog2(RSP_CRDTS + 1);
   localparam int                   c_FIFO_W    = MSH_ADDR_W + MSH_ID_W;
   localparam logic [c_PEND_W-1:0]  c_PEND_ONE  = c_PEND_W'(1);
   localparam logic [c_PEND_W-1:0]  c_INIT_LAST = c_PEND_W'(REQ_DEPTH - 1);
   localparam logic [c_RSP_W-1:0]   c_RSP_ONE   = c_RSP_W'(1);
   localparam logic [c_RSP_W-1:0]   c_RSP_MAX   = c_RSP_W'(RSP_CRDTS);

   msh_row_rd_rsp_fsm_t    r_state;
   msh_row_rd_rsp_fsm_t    w_state_nxt;
   logic                   w_init_adv;
   logic [c_PEND_W-1:0]    r_init_cnt;
   logic [c_PEND_W-1:0]    r_crdt_pend;
   logic [c_PEND_W-1:0]    w_pend_sum;
   logic                   r_crdt_rtn;
   logic [c_RSP_W-1:0]     r_rsp_crdt;
   logic [c_RSP_W-1:0]     w_rsp_crdt_nxt;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_deq;
   logic                   w_enq;
   logic [c_FIFO_W-1:0]    w_head;
   logic [MSH_ADDR_W-1:0]  w_head_addr;
   logic [MSH_ID_W-1:0]    w_head_id;
   logic                   r_pipe_vld [MEM_LAT];
   logic [MSH_ID_W-1:0]    r_pipe_id  [MEM_LAT];

   assign w_head_addr = w_head[c_FIFO_W-1 -: MSH_ADDR_W];
   assign w_head_id   = w_head[MSH_ID_W-1:0];
   assign w_deq       = !w_empty && (r_rsp_crdt != '0);
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_enq       = i_rd_req.vld && (!w_full || w_deq);

   mby_msh_row_rd_req_fifo #(
      .DEPTH (REQ_DEPTH),
      .WIDTH (c_FIFO_W)
   ) u_req_fifo (
      .cclk      (cclk),
      .rst_n     (rst_n),
      .i_wr_en   (w_enq),
      .i_wr_data ({i_rd_req.addr, i_rd_req.id}),
      .i_rd_en   (w_deq),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) r_state <= INIT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == INIT) && (r_init_cnt == c_INIT_LAST)) w_state_nxt = RUN;
   end

   always_comb begin
      w_init_adv = (r_state == INIT);
   end

   assign w_pend_sum = r_crdt_pend + {{(c_PEND_W-1){1'b0}}, w_deq};

   // INIT advertises the full depth; dequeue credits wait in r_crdt_pend.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         r_init_cnt  <= '0;
         r_crdt_pend <= '0;
         r_crdt_rtn  <= 1'b0;
      end else if (w_init_adv) begin
         r_init_cnt  <= r_init_cnt + c_PEND_ONE;
         r_crdt_pend <= w_pend_sum;
         r_crdt_rtn  <= 1'b1;
      end else if (w_pend_sum != '0) begin
         r_crdt_pend <= w_pend_sum - c_PEND_ONE;
         r_crdt_rtn  <= 1'b1;
      end else begin
         r_crdt_rtn  <= 1'b0;
      end
   end

   always_comb begin
      w_rsp_crdt_nxt = r_rsp_crdt;
      if (w_deq && !i_crdt_rtn_for_rd_rsp) begin
         w_rsp_crdt_nxt = r_rsp_crdt - c_RSP_ONE;
      end else if (!w_deq && i_crdt_rtn_for_rd_rsp && (r_rsp_crdt != c_RSP_MAX)) begin
         w_rsp_crdt_nxt = r_rsp_crdt + c_RSP_ONE;
      end
   end

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) r_rsp_crdt <= c_RSP_MAX;
      else        r_rsp_crdt <= w_rsp_crdt_nxt;
   end

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            r_pipe_vld[i] <= 1'b0;
            r_pipe_id[i]  <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_deq;
         r_pipe_id[0]  <= w_head_id;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_id[i]  <= r_pipe_id[i-1];
         end
      end
   end

   assign o_crdt_rtns_for_rd_reqs = {{(MSH_CRDT_W-1){1'b0}}, r_crdt_rtn};
   assign o_mem_rd_en             = w_deq;
   assign o_mem_rd_addr           = w_deq ? w_head_addr : '0;

   always_comb begin
      o_rd_rsp.vld = r_pipe_vld[MEM_LAT-1];
      o_rd_rsp.id  = r_pipe_vld[MEM_LAT-1] ? r_pipe_id[MEM_LAT-1] : '0;
      o_rd_dbus    = r_pipe_vld[MEM_LAT-1] ? i_mem_rd_data : '0;
   end

`ifdef MBY_MSH_ROW_RD_RSP_ERR_CHK_EN
   logic       w_req_ovf;
   logic       w_rsp_ovf;
   logic [1:0] r_err;

   assign w_req_ovf = i_rd_req.vld && w_full && !w_deq;
   assign w_rsp_ovf = i_crdt_rtn_for_rd_rsp && !w_deq && (r_rsp_crdt == c_RSP_MAX);

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) r_err <= 2'b00;
      else        r_err <= r_err | {w_rsp_ovf, w_req_ovf};
   end

   assign o_err = r_err;

   a_no_req_when_full: assert property (@(posedge cclk) disable iff (!rst_n) !w_req_ovf)
      else $warning("read request arrived with request FIFO full");
   a_no_rsp_crdt_ovf: assert property (@(posedge cclk) disable iff (!rst_n) !w_rsp_ovf)
      else $warning("response credit returned beyond RSP_CRDTS");
`else
   assign o_err = 2'b00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mby_msh_row_rd_rsp_ctrl.sv
// ============================================================================
// Module   : tb_mby_msh_row_rd_rsp_ctrl
// Brief    : Directed self-checking bench for mby_msh_row_rd_rsp_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mby_msh_row_rd_rsp_ctrl;
   import mby_msh_pkg::*;

`ifdef MBY_MSH_ROW_RD_RSP_ERR_CHK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic                  cclk  = 1'b0;
   logic                  rst_n = 1'b1;
   msh_row_rd_req_t       i_rd_req;
   msh_row_crdts_t        o_crdt_rtns_for_rd_reqs;
   msh_row_rd_rsp_t       o_rd_rsp;
   msh_dbus_t             o_rd_dbus;
   logic                  i_crdt_rtn_for_rd_rsp;
   logic                  o_mem_rd_en;
   logic [MSH_ADDR_W-1:0] o_mem_rd_addr;
   msh_dbus_t             i_mem_rd_data;
   logic [1:0]            o_err;

   int                    n_chk  = 0;
   int                    n_pass = 0;
   int                    n_rcrdt;
   int                    n_rsp;
   int                    n_iss;
   logic [MSH_ID_W-1:0]   last_id;
   logic [MSH_ADDR_W-1:0] m_addr [3];

   always #5 cclk = ~cclk;

   mby_msh_row_rd_rsp_ctrl u_dut (
      .cclk                    (cclk),
      .rst_n                   (rst_n),
      .i_rd_req                (i_rd_req),
      .o_crdt_rtns_for_rd_reqs (o_crdt_rtns_for_rd_reqs),
      .o_rd_rsp                (o_rd_rsp),
      .o_rd_dbus               (o_rd_dbus),
      .i_crdt_rtn_for_rd_rsp   (i_crdt_rtn_for_rd_rsp),
      .o_mem_rd_en             (o_mem_rd_en),
      .o_mem_rd_addr           (o_mem_rd_addr),
      .i_mem_rd_data           (i_mem_rd_data),
      .o_err                   (o_err)
   );

   // Storage model: data tagged with the address strobed three cycles earlier.
   always @(negedge cclk) begin
      m_addr[0] <= o_mem_rd_addr;
      m_addr[1] <= m_addr[0];
      m_addr[2] <= m_addr[1];
   end
   assign i_mem_rd_data = {32'hCAFE_F00D, 16'h0000, m_addr[2]};

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic clr_cnt();
      n_rcrdt = 0;
      n_rsp   = 0;
      n_iss   = 0;
   endtask

   task automatic tick();
      @(posedge cclk);
      #1;
      n_rcrdt += int'(o_crdt_rtns_for_rd_reqs);
      if (o_mem_rd_en) n_iss++;
      if (o_rd_rsp.vld) begin
         n_rsp++;
         last_id = o_rd_rsp.id;
      end
   endtask

   task automatic set_req(input logic [MSH_ID_W-1:0] id);
      i_rd_req.vld  = 1'b1;
      i_rd_req.id   = id;
      i_rd_req.addr = 16'h0100 + {8'h00, id};
   endtask

   task automatic send_burst(input int n, input logic [MSH_ID_W-1:0] base);
      for (int i = 0; i < n; i++) begin
         set_req(base + MSH_ID_W'(i));
         tick();
      end
      i_rd_req = '0;
   endtask

   task automatic do_reset();
      rst_n                 = 1'b0;
      i_rd_req              = '0;
      i_crdt_rtn_for_rd_rsp = 1'b0;
      #1;
      check("rst_crdt_rtn", 64'(o_crdt_rtns_for_rd_reqs), 64'd0);
      check("rst_rsp_vld", 64'(o_rd_rsp.vld), 64'd0);
      check("rst_mem_en", 64'(o_mem_rd_en), 64'd0);
      check("rst_dbus", o_rd_dbus, 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      clr_cnt();
      tick();
      check("init_first_crdt", 64'(o_crdt_rtns_for_rd_reqs), 64'd1);
      repeat (11) tick();
      check("init_crdt_count", 64'(n_rcrdt), 64'd8);
      check("init_crdt_end", 64'(o_crdt_rtns_for_rd_reqs), 64'd0);
      check("init_no_rsp", 64'(n_rsp), 64'd0);
   endtask

   initial begin
      i_rd_req              = '0;
      i_crdt_rtn_for_rd_rsp = 1'b0;
      last_id               = '0;
      clr_cnt();

      // Reset release with no traffic.
      do_reset();

      // Single request: issue N+1, credit N+2, response N+4.
      i_rd_req.vld  = 1'b1;
      i_rd_req.addr = 16'h0010;
      i_rd_req.id   = 8'd3;
      check("single_no_issue_empty", 64'(o_mem_rd_en), 64'd0);
      tick();
      i_rd_req = '0;
      check("single_issue_en", 64'(o_mem_rd_en), 64'd1);
      check("single_issue_addr", 64'(o_mem_rd_addr), 64'h10);
      check("single_crdt_early", 64'(o_crdt_rtns_for_rd_reqs), 64'd0);
      tick();
      check("single_crdt_pulse", 64'(o_crdt_rtns_for_rd_reqs), 64'd1);
      check("single_one_issue", 64'(o_mem_rd_en), 64'd0);
      tick();
      check("single_rsp_early", 64'(o_rd_rsp.vld), 64'd0);
      tick();
      check("single_rsp_vld", 64'(o_rd_rsp.vld), 64'd1);
      check("single_rsp_id", 64'(o_rd_rsp.id), 64'd3);
      check("single_rsp_data", o_rd_dbus, 64'hCAFE_F00D_0000_0010);
      tick();
      check("single_rsp_done", 64'(o_rd_rsp.vld), 64'd0);
      check("single_dbus_idle", o_rd_dbus, 64'd0);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;

      // Six requests against four response credits.
      clr_cnt();
      send_burst(6, 8'h20);
      repeat (8) tick();
      check("held_issue_count", 64'(n_iss), 64'd4);
      check("held_rsp_count", 64'(n_rsp), 64'd4);
      check("held_no_issue", 64'(o_mem_rd_en), 64'd0);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      check("release_issue", 64'(o_mem_rd_en), 64'd1);
      check("release_addr", 64'(o_mem_rd_addr), 64'h0124);
      tick();
      tick();
      check("release_rsp_early", 64'(o_rd_rsp.vld), 64'd0);
      tick();
      check("release_rsp_vld", 64'(o_rd_rsp.vld), 64'd1);
      check("release_rsp_id", 64'(o_rd_rsp.id), 64'h24);
      check("release_rsp_data", o_rd_dbus, 64'hCAFE_F00D_0000_0124);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      repeat (5) tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      repeat (6) tick();
      check("burst_rsp_total", 64'(n_rsp), 64'd6);
      check("burst_last_id", 64'(last_id), 64'h25);
      check("burst_req_crdts", 64'(n_rcrdt), 64'd6);

      // Issue and credit return together while only one credit remains.
      send_burst(3, 8'h30);
      repeat (6) tick();
      set_req(8'h33);
      tick();
      check("net0_first_issue", 64'(o_mem_rd_en), 64'd1);
      check("net0_first_addr", 64'(o_mem_rd_addr), 64'h0133);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      set_req(8'h34);
      tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      set_req(8'h35);
      check("net0_next_issue", 64'(o_mem_rd_en), 64'd1);
      check("net0_next_addr", 64'(o_mem_rd_addr), 64'h0134);
      tick();
      i_rd_req = '0;
      check("net0_crdt_exhausted", 64'(o_mem_rd_en), 64'd0);

      // Fill the FIFO exactly, then full+dequeue, then full without dequeue.
      do_reset();
      clr_cnt();
      send_burst(12, 8'h50);
      check("fill_issue_count", 64'(n_iss), 64'd4);
      check("fill_no_err", 64'(o_err), 64'd0);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      clr_cnt();
      check("full_deq_issue", 64'(o_mem_rd_en), 64'd1);
      set_req(8'h5C);
      tick();
      check("full_deq_accept", 64'(o_err), 64'd0);
      set_req(8'h5D);
      tick();
      i_rd_req = '0;
      check("full_drop_err", 64'(o_err), {63'd0, ERR_EN});
      i_crdt_rtn_for_rd_rsp = 1'b1;
      repeat (9) tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      repeat (8) tick();
      check("drop_err_sticky", 64'(o_err), {63'd0, ERR_EN});
`ifdef MBY_MSH_ROW_RD_RSP_ERR_CHK_EN
      check("drop_rsp_count", 64'(n_rsp), 64'd9);
      check("drop_last_id", 64'(last_id), 64'h5C);
`endif

      // Fifth response-credit return against four outstanding responses.
      do_reset();
      clr_cnt();
      send_burst(4, 8'h40);
      repeat (6) tick();
      check("ovf_rsp_count", 64'(n_rsp), 64'd4);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      repeat (4) tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      check("ovf_four_ok", 64'(o_err), 64'd0);
      i_crdt_rtn_for_rd_rsp = 1'b1;
      tick();
      i_crdt_rtn_for_rd_rsp = 1'b0;
      check("ovf_fifth_err", 64'(o_err), {62'd0, ERR_EN, 1'b0});
      repeat (3) tick();
      check("ovf_err_sticky", 64'(o_err), {62'd0, ERR_EN, 1'b0});

      // Reset with two reads in flight.
      do_reset();
      send_burst(2, 8'h60);
      do_reset();
      clr_cnt();
      send_burst(5, 8'h70);
      repeat (8) tick();
      check("post_rst_issue_count", 64'(n_iss), 64'd4);
      check("post_rst_rsp_count", 64'(n_rsp), 64'd4);
      check("post_rst_last_id", 64'(last_id), 64'h73);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
